// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the two-port memory access arbiter:
// FSM state encodings, port ids, read/write levels and a grant helper.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic PORT0    = 1'b0;
    localparam logic PORT1    = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // One-hot two-way grant to port id.
    function automatic logic grant_port(input logic [1:0] g);
        return g[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr.sv
// rr_arbiter_2: two-requester arbiter with a registered priority pointer.
// Ports: clk, reset (sync, active-low), req_i[1:0], advance_i, fixed_pri_i, grant_o[1:0].
module rr_arbiter_2
    import mem_access_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       fixed_pri_i,
    output logic [1:0] grant_o
);

    // Port that wins the next two-way conflict.
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (fixed_pri_i || (prio_q == PORT1)) begin
                    grant_o = 2'b10;
                end else begin
                    grant_o = 2'b01;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

    // Priority moves to the port that was not just served.
    always_comb begin
        prio_d = prio_q;
        if (advance_i && (|grant_o)) begin
            prio_d = grant_o[0] ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q <= PORT0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares a single-port memory between fetch (p0) and load/store (p1), one access per 3 cycles.
// Ports: clk, reset (sync, active-low), pN_req_*/pN_rsp_* per requester, mem_* toward memory.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_enable,
    output logic              mem_read_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_e            state_q;
    state_e            state_d;

    logic [1:0]        grant;
    logic              idle;
    logic              cap;
    logic              hs;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              we_q;
    logic              we_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic              port_q;
    logic              port_d;

    logic              p0_rsp_valid_q;
    logic              p0_rsp_valid_d;
    logic              p1_rsp_valid_q;
    logic              p1_rsp_valid_d;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q;
    logic [DATA_W-1:0] p1_rdata_d;

    logic              drive_en;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       ({p1_req_valid, p0_req_valid}),
        .advance_i   (hs),
        .fixed_pri_i (FIXED_PRI),
        .grant_o     (grant)
    );

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign idle         = (state_q == ST_IDLE);
    assign cap          = (state_q == ST_CAPTURE);
    assign p0_req_ready = reset & idle & grant[0];
    assign p1_req_ready = reset & idle & grant[1];
    assign hs           = p0_req_ready | p1_req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (hs) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic toward the memory.
    always_comb begin
        mem_enable     = 1'b0;
        mem_read_write = RW_READ;
        mem_address    = '0;
        drive_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_ISSUE: begin
                mem_enable     = 1'b1;
                mem_read_write = we_q ? RW_WRITE : RW_READ;
                mem_address    = addr_q;
                drive_en       = we_q;
            end
            ST_CAPTURE: begin
            end
            default: begin
            end
        endcase
    end

    assign mem_data = drive_en ? wdata_q : 'z;

    // Request latch, loaded from whichever port completed the handshake.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        if (hs) begin
            port_d = grant_port(grant);
            if (p1_req_ready) begin
                addr_d  = p1_req_addr;
                we_d    = p1_req_we;
                wdata_d = p1_req_wdata;
            end else begin
                addr_d  = p0_req_addr;
                we_d    = p0_req_we;
                wdata_d = p0_req_wdata;
            end
        end
    end

    // Response pulse follows CAPTURE; read data sampled at its closing edge.
    always_comb begin
        p0_rsp_valid_d = cap & (port_q == PORT0);
        p1_rsp_valid_d = cap & (port_q == PORT1);
        p0_rdata_d     = p0_rdata_q;
        p1_rdata_d     = p1_rdata_q;
        if (cap && !we_q) begin
            if (port_q == PORT1) begin
                p1_rdata_d = mem_data;
            end else begin
                p0_rdata_d = mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            port_q         <= PORT0;
            p0_rsp_valid_q <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p0_rdata_q     <= '0;
            p1_rdata_q     <= '0;
        end else begin
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            port_q         <= port_d;
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p0_rdata_q     <= p0_rdata_d;
            p1_rdata_q     <= p1_rdata_d;
        end
    end

    assign p0_rsp_valid = p0_rsp_valid_q;
    assign p1_rsp_valid = p1_rsp_valid_q;
    assign p0_rsp_rdata = p0_rdata_q;
    assign p1_rsp_rdata = p1_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: round-robin instance with a memory model,
// plus a fixed-priority instance for the priority checks.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_p0_v, a_p0_rdy, a_p0_we, a_p0_rv;
    logic [15:0] a_p0_addr, a_p0_wd, a_p0_rd;
    logic        a_p1_v, a_p1_rdy, a_p1_we, a_p1_rv;
    logic [15:0] a_p1_addr, a_p1_wd, a_p1_rd;
    logic [15:0] a_maddr;
    logic        a_men, a_mrw;
    wire  [15:0] a_md;

    logic        b_p0_v, b_p0_rdy, b_p0_we, b_p0_rv;
    logic [15:0] b_p0_addr, b_p0_wd, b_p0_rd;
    logic        b_p1_v, b_p1_rdy, b_p1_we, b_p1_rv;
    logic [15:0] b_p1_addr, b_p1_wd, b_p1_rd;
    logic [15:0] b_maddr;
    logic        b_men, b_mrw;
    wire  [15:0] b_md;

    int tests = 0;
    int fails = 0;

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRI(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .p0_req_valid(a_p0_v), .p0_req_ready(a_p0_rdy), .p0_req_we(a_p0_we),
        .p0_req_addr(a_p0_addr), .p0_req_wdata(a_p0_wd),
        .p0_rsp_valid(a_p0_rv), .p0_rsp_rdata(a_p0_rd),
        .p1_req_valid(a_p1_v), .p1_req_ready(a_p1_rdy), .p1_req_we(a_p1_we),
        .p1_req_addr(a_p1_addr), .p1_req_wdata(a_p1_wd),
        .p1_rsp_valid(a_p1_rv), .p1_rsp_rdata(a_p1_rd),
        .mem_address(a_maddr), .mem_enable(a_men), .mem_read_write(a_mrw),
        .mem_data(a_md)
    );

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRI(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .p0_req_valid(b_p0_v), .p0_req_ready(b_p0_rdy), .p0_req_we(b_p0_we),
        .p0_req_addr(b_p0_addr), .p0_req_wdata(b_p0_wd),
        .p0_rsp_valid(b_p0_rv), .p0_rsp_rdata(b_p0_rd),
        .p1_req_valid(b_p1_v), .p1_req_ready(b_p1_rdy), .p1_req_we(b_p1_we),
        .p1_req_addr(b_p1_addr), .p1_req_wdata(b_p1_wd),
        .p1_rsp_valid(b_p1_rv), .p1_rsp_rdata(b_p1_rd),
        .mem_address(b_maddr), .mem_enable(b_men), .mem_read_write(b_mrw),
        .mem_data(b_md)
    );

    // Synchronous memory: read data is driven in the cycle after the enable cycle.
    logic [15:0] mem [0:65535];
    logic        mdrv;
    logic [15:0] mdq;
    assign a_md = mdrv ? mdq : 'z;

    always @(posedge clk) begin
        if (!reset) begin
            mdrv <= 1'b0;
        end else begin
            mdrv <= 1'b0;
            if (a_men && a_mrw) begin
                mdq  <= mem[a_maddr];
                mdrv <= 1'b1;
            end else if (a_men) begin
                mem[a_maddr] <= a_md;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Released bus reads as z on 4-state tools and 0 on 2-state tools.
    task automatic chkz(input string tag, input logic [15:0] obs);
        tests++;
        assert ((obs === 16'hzzzz) || (obs === 16'h0000)) else begin
            fails++;
            $error("FAIL %s observed=%h expected=released", tag, obs);
        end
    endtask

    task automatic setp(input int p, input logic v, input logic we,
                        input logic [15:0] ad, input logic [15:0] wd);
        if (p == 0) begin
            a_p0_v = v; a_p0_we = we; a_p0_addr = ad; a_p0_wd = wd;
        end else begin
            a_p1_v = v; a_p1_we = we; a_p1_addr = ad; a_p1_wd = wd;
        end
    endtask

    int w;

    initial begin
        reset = 1'b0;
        setp(0, 1'b1, 1'b0, 16'h0, 16'h0);
        setp(1, 1'b1, 1'b0, 16'h0, 16'h0);
        b_p0_v = 1'b1; b_p0_we = 1'b0; b_p0_addr = 16'h0; b_p0_wd = 16'h0;
        b_p1_v = 1'b1; b_p1_we = 1'b0; b_p1_addr = 16'h0; b_p1_wd = 16'h0;

        // Reset held with both ports requesting.
        repeat (2) begin
            mid();
            chkb("rst_a_rdy0", a_p0_rdy, 1'b0);
            chkb("rst_a_rdy1", a_p1_rdy, 1'b0);
            chkb("rst_b_rdy0", b_p0_rdy, 1'b0);
            chkb("rst_b_rdy1", b_p1_rdy, 1'b0);
            chkb("rst_rv0", a_p0_rv, 1'b0);
            chkb("rst_rv1", a_p1_rv, 1'b0);
            chkb("rst_men", a_men, 1'b0);
            chkb("rst_mrw", a_mrw, 1'b1);
            chk("rst_maddr", a_maddr, 16'h0000);
            chk("rst_rd0", a_p0_rd, 16'h0000);
            chkz("rst_md", a_md);
            tick();
        end
        reset = 1'b1;
        setp(0, 1'b0, 1'b0, 16'h0, 16'h0);
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        b_p0_v = 1'b0;
        b_p1_v = 1'b0;

        // P1 write 0x0010 <= 0xBEEF, then read it back.
        setp(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        mid();
        chkb("t2_wr_rdy1", a_p1_rdy, 1'b1);
        chkb("t2_wr_rdy0", a_p0_rdy, 1'b0);
        tick();
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chkb("t2_iss_men", a_men, 1'b1);
        chkb("t2_iss_mrw", a_mrw, 1'b0);
        chk("t2_iss_addr", a_maddr, 16'h0010);
        chk("t2_iss_md", a_md, 16'hBEEF);
        tick();
        mid();
        chkb("t2_cap_men", a_men, 1'b0);
        chkz("t2_cap_md", a_md);
        chkb("t2_cap_rv1", a_p1_rv, 1'b0);
        tick();
        setp(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        mid();
        chkb("t2_wack", a_p1_rv, 1'b1);
        chk("t2_wack_rd", a_p1_rd, 16'h0000);
        chkb("t2_wack_rv0", a_p0_rv, 1'b0);
        chkb("t2_rd_rdy1", a_p1_rdy, 1'b1);
        tick();
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chkb("t2_rd_mrw", a_mrw, 1'b1);
        chkb("t2_rd_men", a_men, 1'b1);
        chkb("t2_pulse_once", a_p1_rv, 1'b0);
        chkz("t2_rd_iss_md", a_md);
        tick();
        mid();
        chkb("t2_rd_cap_rv", a_p1_rv, 1'b0);
        tick();
        mid();
        chkb("t2_rd_rv", a_p1_rv, 1'b1);
        chk("t2_rd_data", a_p1_rd, 16'hBEEF);
        tick();

        // Bus check: P0 write 0xFFFF <= 0x1234, P1 reads it back.
        setp(0, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
        mid();
        chkb("t5_rdy0", a_p0_rdy, 1'b1);
        chkz("t5_idle_md", a_md);
        tick();
        setp(0, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("t5_iss_md", a_md, 16'h1234);
        chk("t5_iss_addr", a_maddr, 16'hFFFF);
        chkb("t5_iss_mrw", a_mrw, 1'b0);
        tick();
        mid();
        chkz("t5_cap_md", a_md);
        chkb("t5_cap_men", a_men, 1'b0);
        tick();
        setp(1, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        mid();
        chkb("t5_wack", a_p0_rv, 1'b1);
        chkz("t5_ack_md", a_md);
        chkb("t5_rdy1", a_p1_rdy, 1'b1);
        tick();
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("t5_rd_addr", a_maddr, 16'hFFFF);
        tick();
        tick();
        mid();
        chkb("t5_rd_rv", a_p1_rv, 1'b1);
        chk("t5_rd_data", a_p1_rd, 16'h1234);
        tick();

        // Round-robin contention: both ports read continuously.
        setp(0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        setp(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        for (int i = 0; i < 4; i++) begin
            w = i % 2;
            mid();
            chkb("t3_rdy0", a_p0_rdy, w == 0);
            chkb("t3_rdy1", a_p1_rdy, w == 1);
            if (i > 0) begin
                chkb("t3_rv0", a_p0_rv, w == 1);
                chkb("t3_rv1", a_p1_rv, w == 0);
                if (w == 1) chk("t3_rd0", a_p0_rd, 16'h1234);
                else        chk("t3_rd1", a_p1_rd, 16'hBEEF);
            end
            tick();
            mid();
            chkb("t3_busy_rdy", a_p0_rdy | a_p1_rdy, 1'b0);
            tick();
            tick();
        end
        setp(0, 1'b0, 1'b0, 16'h0, 16'h0);
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chkb("t3_last_rv1", a_p1_rv, 1'b1);
        chkb("t3_last_rv0", a_p0_rv, 1'b0);
        chk("t3_last_rd1", a_p1_rd, 16'hBEEF);
        tick();

        // Fixed priority: port 1 wins until it drops valid.
        b_p0_v = 1'b1;
        b_p1_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chkb("t4_rdy1", b_p1_rdy, 1'b1);
            chkb("t4_rdy0", b_p0_rdy, 1'b0);
            if (i > 0) chkb("t4_rv1", b_p1_rv, 1'b1);
            tick();
            tick();
            tick();
        end
        b_p1_v = 1'b0;
        mid();
        chkb("t4_p0_rdy", b_p0_rdy, 1'b1);
        tick();
        b_p0_v = 1'b0;
        tick();
        tick();
        mid();
        chkb("t4_p0_rv", b_p0_rv, 1'b1);
        chkb("t4_p1_rv", b_p1_rv, 1'b0);
        tick();

        // Reset during the CAPTURE cycle of a read.
        setp(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        mid();
        chkb("t6_rdy0", a_p0_rdy, 1'b1);
        tick();
        setp(0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        reset = 1'b0;
        mid();
        chkb("t6_cap_men", a_men, 1'b0);
        tick();
        reset = 1'b1;
        setp(1, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        mid();
        chkb("t6_no_rsp", a_p0_rv, 1'b0);
        chkb("t6_men", a_men, 1'b0);
        chkz("t6_md", a_md);
        chkb("t6_idle_rdy1", a_p1_rdy, 1'b1);
        chk("t6_rd0_clr", a_p0_rd, 16'h0000);
        tick();
        setp(1, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chkb("t6_iss_rv0", a_p0_rv, 1'b0);
        chkb("t6_iss_men", a_men, 1'b1);
        tick();
        mid();
        chkb("t6_cap_rv0", a_p0_rv, 1'b0);
        tick();
        mid();
        chkb("t6_new_rv1", a_p1_rv, 1'b1);
        chk("t6_new_rd1", a_p1_rd, 16'h1234);
        chkb("t6_new_rv0", a_p0_rv, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
